// File: rtl/updown_cmd_seq.sv
// updown_cmd_seq: command sequencer that drives an external up/down counter.
// It accepts LOAD / UP / DOWN / NOP commands, strobes the counter for the
// requested number of steps, and reports a one-cycle done pulse together with
// an abort flag and a saturating count of the counter's carry/borrow events.
module updown_cmd_seq #(
  parameter int N      = 10,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [N-1:0]      cmd_arg,
  input  logic              abort,
  input  logic              cnt_cout,
  output logic              Load,
  output logic [N-1:0]      In,
  output logic              Din,
  output logic              En,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]        OP_LOAD  = 2'b00;
  localparam logic [1:0]        OP_UP    = 2'b01;
  localparam logic [1:0]        OP_DOWN  = 2'b10;
  localparam logic [N-1:0]      REM_ONE  = N'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t              state_q, state_d;
  logic [N-1:0]        arg_q, arg_d;
  logic [N-1:0]        rem_q, rem_d;
  logic                dir_q, dir_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic                ab_q, ab_d;
  logic                accept;

  // State and latched-command registers; reset parks everything in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      arg_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      ab_q    <= ab_d;
    end
  end

  // Next-state logic: command decode, step countdown, abort and wrap tally.
  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    ab_d    = ab_q;
    accept  = cmd_valid && cmd_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          arg_d  = cmd_arg;
          rem_d  = cmd_arg;
          dir_d  = (cmd_op == OP_UP);
          wrap_d = '0;
          ab_d   = 1'b0;
          case (cmd_op)
            OP_LOAD:       state_d = S_LOAD;
            OP_UP, OP_DOWN: state_d = (cmd_arg != '0) ? S_RUN : S_DONE;
            default:       state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN: begin
        if (abort) begin
          // The step is not issued, so its carry is not counted either.
          ab_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          // remaining is never 0 here, so the countdown cannot underflow.
          rem_d = rem_q - REM_ONE;
          if (cnt_cout && (wrap_q != WRAP_MAX)) wrap_d = wrap_q + WRAP_ONE;
          if (rem_q == REM_ONE) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the current state and are forced low while rst is high.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    busy      = (state_q != S_IDLE) && !rst;
    Load      = (state_q == S_LOAD) && !rst;
    In        = Load ? arg_q : '0;
    Din       = (state_q == S_RUN) && !rst && dir_q;
    En        = (state_q == S_RUN) && !rst && !abort;
    done      = (state_q == S_DONE) && !rst;
    aborted   = ab_q && !rst;
    wrap_cnt  = rst ? '0 : wrap_q;
  end

endmodule

// File: tb/tb_updown_cmd_seq.sv
// Bench for updown_cmd_seq: a cycle-indexed reference model checks every
// output every cycle, a small downstream counter generates cnt_cout, and a
// vector table checks latency / wrap / abort results against fixed values.
module tb_updown_cmd_seq;
  localparam int N  = 10;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, abort, cnt_cout;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_arg, In;
  logic          Load, Din, En, busy, done, aborted;
  logic [WW-1:0] wrap_cnt;

  always #5 clk = ~clk;

  updown_cmd_seq #(.N(N), .WRAP_W(WW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .cnt_cout(cnt_cout),
    .Load(Load), .In(In), .Din(Din), .En(En), .busy(busy), .done(done),
    .aborted(aborted), .wrap_cnt(wrap_cnt)
  );

  int total = 0;
  int bad   = 0;

  // staged stimulus, applied on the falling edge
  logic          n_rst = 1'b1, n_valid = 1'b0, n_abort = 1'b0;
  logic [1:0]    n_op = 2'b11;
  logic [N-1:0]  n_arg = '0;
  logic          rnd_cout = 1'b0, force_cout = 1'b0;

  // downstream counter driven from the model's expected strobes
  logic [N-1:0]  ctr = '0;

  // reference model: cycle index since accept, abort cycle, results
  bit m_act = 0;
  int m_op = 0, m_arg = 0, m_cyc = 0, m_abc = 0, m_wrap = 0;
  bit m_ab = 0;

  // DUT values captured at the sample point
  logic d_done, d_ab, d_ready, d_busy, d_en;
  logic [WW-1:0] d_wrap;

  task automatic step();
    logic e_ready, e_busy, e_load, e_din, e_en, e_done, e_ab;
    logic [N-1:0]  e_in;
    logic [WW-1:0] e_wrap;
    bit cnting;
    int last;
    @(negedge clk);
    rst = n_rst; cmd_valid = n_valid; cmd_op = n_op; cmd_arg = n_arg; abort = n_abort;
    e_ready = 0; e_busy = 0; e_load = 0; e_din = 0; e_en = 0; e_done = 0; e_ab = 0;
    e_in = '0; e_wrap = '0; cnting = 0;
    if (!n_rst) begin
      e_ready = !m_act;
      e_busy  = m_act;
      e_wrap  = m_wrap[WW-1:0];
      e_ab    = m_ab;
      if (m_act) begin
        if (m_op == 0) begin
          e_load = (m_cyc == 1);
          e_done = (m_cyc == 2);
        end else if (m_op == 3 || m_arg == 0) begin
          e_done = (m_cyc == 1);
        end else begin
          last   = (m_abc != 0) ? m_abc : m_arg;
          cnting = (m_abc == 0) && (m_cyc <= m_arg);
          e_done = (m_cyc == last + 1);
        end
      end
      if (e_load) e_in = m_arg[N-1:0];
      if (cnting) begin
        e_en  = !n_abort;
        e_din = (m_op == 1);
      end
    end
    cnt_cout = rnd_cout | force_cout | (e_din ? (ctr == {N{1'b1}}) : (ctr == '0));
    #1;
    total++;
    if ({cmd_ready, busy, Load, In, Din, En, done, aborted, wrap_cnt} !==
        {e_ready, e_busy, e_load, e_in, e_din, e_en, e_done, e_ab, e_wrap}) begin
      bad++;
      $display("FAIL outputs t=%0t got rdy=%b bsy=%b ld=%b in=%h din=%b en=%b dn=%b ab=%b wr=%0d want rdy=%b bsy=%b ld=%b in=%h din=%b en=%b dn=%b ab=%b wr=%0d",
               $time, cmd_ready, busy, Load, In, Din, En, done, aborted, wrap_cnt,
               e_ready, e_busy, e_load, e_in, e_din, e_en, e_done, e_ab, e_wrap);
    end
    total++;
    if (Load && En) begin
      bad++;
      $display("FAIL load_en_overlap t=%0t got Load=%b En=%b want not both", $time, Load, En);
    end
    d_done = done; d_wrap = wrap_cnt; d_ab = aborted; d_ready = cmd_ready;
    d_busy = busy; d_en = En;
    @(posedge clk);
    if (e_load) ctr = m_arg[N-1:0];
    else if (e_en) ctr = e_din ? ctr + N'(1) : ctr - N'(1);
    if (n_rst) begin
      m_act = 0; m_wrap = 0; m_ab = 0;
    end else if (m_act) begin
      if (e_done) m_act = 0;
      else begin
        if (cnting) begin
          if (n_abort) begin m_abc = m_cyc; m_ab = 1; end
          else if (cnt_cout && m_wrap < (1 << WW) - 1) m_wrap++;
        end
        m_cyc++;
      end
    end else if (n_valid) begin
      m_act = 1; m_op = int'(n_op); m_arg = int'(n_arg);
      m_cyc = 1; m_abc = 0; m_wrap = 0; m_ab = 0;
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] arg;
    int           abmode;   // 0 none, k>0 abort on k-th cycle after accept, -1 held
    bit           cout_all;
    int           exp_lat;
    int           exp_wrap;
    bit           exp_ab;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{2'b00, 10'h155,  0, 0,    2,   0, 0};
    vecs[1]  = '{2'b00, 10'h3FE,  0, 0,    2,   0, 0};
    vecs[2]  = '{2'b01, 10'd4,    0, 0,    5,   1, 0};
    vecs[3]  = '{2'b10, 10'd10,   3, 0,    4,   0, 1};
    vecs[4]  = '{2'b01, 10'd0,    0, 0,    1,   0, 0};
    vecs[5]  = '{2'b11, 10'd7,    0, 0,    1,   0, 0};
    vecs[6]  = '{2'b10, 10'd3,    0, 0,    4,   1, 0};
    vecs[7]  = '{2'b00, 10'd0,    0, 0,    2,   0, 0};
    vecs[8]  = '{2'b01, 10'd1023, 0, 0, 1024,   0, 0};
    vecs[9]  = '{2'b01, 10'd300,  0, 1,  301, 255, 0};
    vecs[10] = '{2'b00, 10'h2AA, -1, 0,    2,   0, 0};
    vecs[11] = '{2'b01, 10'd2,   -1, 0,    2,   0, 1};

    // reset, then release
    repeat (3) step();
    n_rst = 0;
    step();
    check("ready_after_reset", int'(d_ready), 1);

    // table-driven commands
    foreach (vecs[i]) begin
      n_valid = 1; n_op = vecs[i].op; n_arg = vecs[i].arg;
      n_abort = (vecs[i].abmode < 0);
      step();
      n_valid = 0;
      lat = 0;
      for (int c = 1; c <= 1100 && lat == 0; c++) begin
        n_abort = (vecs[i].abmode < 0) || (vecs[i].abmode == c);
        force_cout = vecs[i].cout_all;
        step();
        if (d_done) lat = c;
      end
      force_cout = 0; n_abort = 0;
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_wrap", i), int'(d_wrap), vecs[i].exp_wrap);
      check($sformatf("vec%0d_aborted", i), int'(d_ab), int'(vecs[i].exp_ab));
    end
    step();
    check("ready_after_nop", int'(d_ready), 1);

    // cmd_valid held high across back-to-back commands
    n_valid = 1;
    for (int i = 0; i < 40; i++) begin
      n_op = 2'(i % 4);
      n_arg = N'(i % 5);
      step();
    end
    n_valid = 0;
    repeat (8) step();

    // reset during a 20-step UP at step 5
    n_valid = 1; n_op = 2'b01; n_arg = 10'd20;
    step();
    n_valid = 0;
    repeat (5) step();
    n_rst = 1;
    step();
    check("rst_run_en", int'(d_en), 0);
    check("rst_run_done", int'(d_done), 0);
    step();
    check("rst_run_busy", int'(d_busy), 0);
    n_rst = 0;
    step();
    check("rst_run_ready", int'(d_ready), 1);

    // reset landing on the LOAD cycle
    n_valid = 1; n_op = 2'b00; n_arg = 10'h0F0;
    step();
    n_valid = 0; n_rst = 1;
    step();
    check("rst_load_done", int'(d_done), 0);
    n_rst = 0;
    step();
    check("rst_load_ready", int'(d_ready), 1);
    step();
    check("rst_load_no_done", int'(d_done), 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      n_valid  = ($urandom_range(0, 2) != 0);
      n_op     = 2'($urandom_range(0, 3));
      n_arg    = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 40)) : N'($urandom_range(0, 5));
      n_abort  = ($urandom_range(0, 9) == 0);
      n_rst    = ($urandom_range(0, 99) < 2);
      rnd_cout = ($urandom_range(0, 3) == 0);
      step();
    end
    n_rst = 0; n_valid = 0; n_abort = 0; rnd_cout = 0;
    repeat (50) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/updown_cmd_seq.md
UPDOWN_CMD_SEQ -- requirements
Module: updown_cmd_seq

Interface
REQ-001 Parameter N, default 10, SHALL set the width of the counter being driven and of cmd_arg.
REQ-002 Parameter WRAP_W, default 8, SHALL set the width of wrap_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL indicate that a command is offered.
REQ-006 cmd_ready  output  1  SHALL indicate that the sequencer accepts a command this cycle.
REQ-007 cmd_op  input  2  SHALL encode the command: 00 LOAD, 01 UP, 10 DOWN, 11 NOP.
REQ-008 cmd_arg  input  N  SHALL carry the load value for LOAD, or the step count for UP/DOWN.
REQ-009 abort  input  1  SHALL request early termination of a RUN.
REQ-010 cnt_cout  input  1  SHALL be the carry/borrow out from the downstream counter.
REQ-011 Load  output  1  SHALL be the counter load strobe.
REQ-012 In  output  N  SHALL be the counter load value.
REQ-013 Din  output  1  SHALL be the counter direction: 1 up, 0 down.
REQ-014 En  output  1  SHALL be the counter count enable.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  SHALL be a one-cycle completion pulse.
REQ-017 aborted  output  1  SHALL be valid with done and SHALL be high if the command ended by abort.
REQ-018 wrap_cnt  output  WRAP_W  SHALL report the number of cnt_cout events seen during the last command.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, LOAD, RUN and DONE.
REQ-020 cmd_ready SHALL equal (state==IDLE) && !rst.
REQ-021 A command SHALL be accepted only on a cycle where cmd_valid && cmd_ready; on accept, op, arg and direction SHALL be latched, and wrap_cnt and aborted SHALL clear.
REQ-022 IDLE SHALL transition on accept as follows: LOAD goes to LOAD; UP/DOWN with arg>0 goes to RUN with remaining=arg; UP/DOWN with arg==0 goes to DONE; NOP goes to DONE.
REQ-023 In the LOAD state, Load SHALL be 1 and In SHALL equal the latched arg for exactly one cycle, and the next state SHALL be DONE.
REQ-024 In the RUN state, En SHALL be 1 && !abort, Din SHALL equal the latched direction (UP=1, DOWN=0), and Load SHALL be 0.
REQ-025 Each RUN cycle with En=1 SHALL decrement remaining; when remaining==1 and there is no abort, the next state SHALL be DONE.
REQ-026 abort=1 in RUN SHALL suppress En that same cycle, set aborted, and move to DONE next cycle.
REQ-027 abort outside RUN SHALL be ignored.
REQ-028 A RUN cycle with En=1 and cnt_cout=1 SHALL increment wrap_cnt, saturating at 2^WRAP_W-1.
REQ-029 cnt_cout SHALL be ignored when En=0.
REQ-030 DONE SHALL assert done for one cycle, SHALL hold wrap_cnt and aborted, and the next state SHALL be IDLE.
REQ-031 Latency: a LOAD accepted at cycle t SHALL assert Load at t+1 and done at t+2.
REQ-032 Latency: an UP/DOWN of k steps accepted at t SHALL assert En on cycles t+1..t+k and done at t+k+1.
REQ-033 Latency: NOP, or an arg of 0, accepted at t SHALL assert done at t+1 with no Load or En.
REQ-034 The maximum step count 2^N-1 SHALL complete without wrap of remaining.
REQ-035 Load and En SHALL never be high in the same cycle.
REQ-036 In SHALL read 0 when Load=0, and Din SHALL read 0 outside RUN.

Reset
REQ-037 While rst=1, the state SHALL be IDLE, and Load, En, Din, In, busy, done, aborted, wrap_cnt and cmd_ready SHALL all be 0.
REQ-038 rst asserted mid-RUN or mid-LOAD SHALL drop En and Load on the following edge, without a done pulse.
REQ-039 cmd_ready SHALL rise on the first cycle after rst deasserts.

Verification
REQ-040 LOAD with arg=0x155 -> Load=1 and In=0x155 for one cycle, done one cycle later, wrap_cnt=0, aborted=0.
REQ-041 Counter preloaded to 0x3FE, then UP with arg=4 -> En high for 4 cycles with Din=1, a single cnt_cout pulse, done with wrap_cnt=1.
REQ-042 DOWN with arg=10, abort pulsed on the 3rd En cycle -> exactly 2 counting cycles, done the next cycle with aborted=1.
REQ-043 UP with arg=0, and NOP -> done at t+1; Load and En stay 0; cmd_ready returns at t+2.
REQ-044 cmd_valid held high across back-to-back commands -> each accepted only in IDLE, with no overlap of Load and En.
REQ-045 rst asserted during a RUN with arg=20 at step 5 -> En low after the edge, all outputs 0, no done, cmd_ready=1 after release.
